pixel_coord_gen: RTL and testbench

- Upstream coordinate generator for the camera pixel stream.
- Converts raw video sync and data-valid into registered pixel coordinates gr_x/gr_y plus a per-pixel enable.
- These outputs drive the ROI/border masking stage.
- Also produces frame-start and frame-count status and a line-length error flag for the fish-counting logic.

---
 rtl/pixel_coord_gen.sv | 118 +++++++++++
 tb/tb_pixel_coord_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pixel_coord_gen.sv
// pixel_coord_gen
// Turns raw vsync/hsync/pix_valid from the camera into registered pixel
// coordinates (gr_x, gr_y) with a per-pixel enable, plus frame-start,
// frame-count and line-length-error status. Every output is a flop.
module pixel_coord_gen #(
  parameter int   H_ACTIVE  = 720,
  parameter int   V_ACTIVE  = 576,
  parameter logic VSYNC_POL = 1'b0,
  parameter logic HSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        hsync,
  input  logic        pix_valid,
  output logic [10:0] gr_x,
  output logic [9:0]  gr_y,
  output logic        enable,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic        line_err
);

  localparam logic [10:0] X_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] X_MAX = 11'h7FF;
  localparam logic [9:0]  Y_LIM = 10'(V_ACTIVE);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_reg;
  logic        vsync_reg;
  logic        hsync_reg;
  logic        pix_valid_reg;
  logic [10:0] x_cnt_reg;
  logic [9:0]  y_cnt_reg;
  logic        line_open_reg;

  logic        vs_edge;
  logic        hs_edge;
  logic        pv_fall;
  logic        line_close;
  logic [9:0]  y_inc;
  logic [10:0] x_eff;
  logic [9:0]  y_eff;
  logic [10:0] x_inc;
  logic        in_frame;

  // Sync edges, line-close detection and the coordinates a pixel on this
  // cycle would take. When a line closes on the same cycle as a pixel
  // (hsync edge with pix_valid high), the pixel belongs to the new line,
  // so the effective coordinates already reflect the close.
  always_comb begin
    vs_edge    = (vsync == VSYNC_POL) && (vsync_reg != VSYNC_POL);
    hs_edge    = (hsync == HSYNC_POL) && (hsync_reg != HSYNC_POL);
    pv_fall    = pix_valid_reg && !pix_valid;
    line_close = (state_reg == ACTIVE) && line_open_reg && (pv_fall || hs_edge);
    y_inc      = (y_cnt_reg >= Y_LIM) ? Y_LIM : (y_cnt_reg + 10'd1);
    x_eff      = line_close ? 11'd0 : x_cnt_reg;
    y_eff      = line_close ? y_inc : y_cnt_reg;
    x_inc      = (x_eff == X_MAX) ? X_MAX : (x_eff + 11'd1);
    in_frame   = (x_eff < X_LIM) && (y_eff < Y_LIM);
  end

  // Frame/line state machine with registered coordinate and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      vsync_reg     <= ~VSYNC_POL;
      hsync_reg     <= ~HSYNC_POL;
      pix_valid_reg <= 1'b0;
      x_cnt_reg     <= '0;
      y_cnt_reg     <= '0;
      line_open_reg <= 1'b0;
      gr_x          <= '0;
      gr_y          <= '0;
      enable        <= 1'b0;
      frame_start   <= 1'b0;
      frame_cnt     <= '0;
      line_err      <= 1'b0;
    end else begin
      vsync_reg     <= vsync;
      hsync_reg     <= hsync;
      pix_valid_reg <= pix_valid;
      enable        <= 1'b0;
      frame_start   <= 1'b0;
      line_err      <= 1'b0;

      if (vs_edge) begin
        // New frame: an open line is abandoned silently and any pixel on
        // this cycle is discarded.
        state_reg     <= ACTIVE;
        frame_start   <= 1'b1;
        frame_cnt     <= frame_cnt + 16'd1;
        x_cnt_reg     <= '0;
        y_cnt_reg     <= '0;
        line_open_reg <= 1'b0;
      end else if (state_reg == ACTIVE) begin
        line_err  <= line_close && (x_cnt_reg != X_LIM);
        y_cnt_reg <= y_eff;
        if (pix_valid) begin
          line_open_reg <= 1'b1;
          x_cnt_reg     <= x_inc;
          if (in_frame) begin
            enable <= 1'b1;
            gr_x   <= x_eff;
            gr_y   <= y_eff;
          end
        end else begin
          x_cnt_reg <= x_eff;
          if (line_close) begin
            line_open_reg <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Directed testbench for pixel_coord_gen with a 4x3 active window.
module tb_pixel_coord_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        hsync;
  logic        pix_valid;
  logic [10:0] gr_x;
  logic [9:0]  gr_y;
  logic        enable;
  logic        frame_start;
  logic [15:0] frame_cnt;
  logic        line_err;

  int tests = 0;
  int fails = 0;
  int lx = 0;
  int ly = 0;

  pixel_coord_gen #(
    .H_ACTIVE (4),
    .V_ACTIVE (3),
    .VSYNC_POL(1'b0),
    .HSYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .hsync      (hsync),
    .pix_valid  (pix_valid),
    .gr_x       (gr_x),
    .gr_y       (gr_y),
    .enable     (enable),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt),
    .line_err   (line_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then check the registered outputs it produced.
  // gr_x/gr_y must match the last enabled coordinates (they hold otherwise).
  task automatic step(input string tag, input logic v, input logic h, input logic p,
                      input logic en, input int x, input int y,
                      input logic fs, input logic le);
    vsync = v; hsync = h; pix_valid = p;
    @(posedge clk); #1;
    chk({tag, ".enable"}, {31'd0, enable}, {31'd0, en});
    if (en) begin lx = x; ly = y; end
    chk({tag, ".gr_x"}, {21'd0, gr_x}, lx);
    chk({tag, ".gr_y"}, {22'd0, gr_y}, ly);
    chk({tag, ".frame_start"}, {31'd0, frame_start}, {31'd0, fs});
    chk({tag, ".line_err"}, {31'd0, line_err}, {31'd0, le});
    $display("[TB] %s v=%0b h=%0b p=%0b -> en=%0b x=%0d y=%0d fs=%0b le=%0b fc=%0d",
             tag, v, h, p, enable, gr_x, gr_y, frame_start, line_err, frame_cnt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gr_x"}, {21'd0, gr_x}, 0);
    chk({tag, ".gr_y"}, {22'd0, gr_y}, 0);
    chk({tag, ".enable"}, {31'd0, enable}, 0);
    chk({tag, ".frame_start"}, {31'd0, frame_start}, 0);
    chk({tag, ".frame_cnt"}, {16'd0, frame_cnt}, 0);
    chk({tag, ".line_err"}, {31'd0, line_err}, 0);
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b1; hsync = 1'b1; pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    // Pixels before any vsync are ignored.
    for (int i = 0; i < 3; i++) step("pre_vsync", 1, 1, 1, 0, 0, 0, 0, 0);
    step("pre_vsync_idle", 1, 1, 0, 0, 0, 0, 0, 0);

    // Frame 1: three 4-pixel lines.
    step("t1_vsync", 0, 1, 0, 0, 0, 0, 1, 0);
    chk("t1_frame_cnt", {16'd0, frame_cnt}, 1);
    step("t1_post_vsync", 1, 1, 0, 0, 0, 0, 0, 0);
    for (int l = 0; l < 3; l++) begin
      for (int x = 0; x < 4; x++) step("t1_pix", 1, 1, 1, 1, x, l, 0, 0);
      step("t1_close", 1, 1, 0, 0, 0, 0, 0, 0);
      step("t1_idle", 1, 1, 0, 0, 0, 0, 0, 0);
    end
    chk("t1_frame_cnt_end", {16'd0, frame_cnt}, 1);

    // Fourth line falls outside the frame.
    for (int x = 0; x < 4; x++) step("t3_pix", 1, 1, 1, 0, 0, 0, 0, 0);
    step("t3_close", 1, 1, 0, 0, 0, 0, 0, 0);
    step("t3_idle", 1, 1, 0, 0, 0, 0, 0, 0);
    for (int x = 0; x < 2; x++) step("t3_pix2", 1, 1, 1, 0, 0, 0, 0, 0);
    step("t3_close2", 1, 1, 0, 0, 0, 0, 0, 1);

    // Frame 2: a 5-pixel line raises line_err once.
    step("t2_vsync", 0, 1, 0, 0, 0, 0, 1, 0);
    chk("t2_frame_cnt", {16'd0, frame_cnt}, 2);
    step("t2_post_vsync", 1, 1, 0, 0, 0, 0, 0, 0);
    for (int x = 0; x < 4; x++) step("t2_pix", 1, 1, 1, 1, x, 0, 0, 0);
    step("t2_pix5", 1, 1, 1, 0, 0, 0, 0, 0);
    step("t2_close", 1, 1, 0, 0, 0, 0, 0, 1);
    step("t2_idle", 1, 1, 0, 0, 0, 0, 0, 0);
    for (int x = 0; x < 4; x++) step("t2_next", 1, 1, 1, 1, x, 1, 0, 0);
    step("t2_next_close", 1, 1, 0, 0, 0, 0, 0, 0);

    // Vsync mid-line: the pixel on the edge is dropped, next pixel is (0,0).
    step("t4_pix", 1, 1, 1, 1, 0, 2, 0, 0);
    step("t4_pix", 1, 1, 1, 1, 1, 2, 0, 0);
    step("t4_vsync", 0, 1, 1, 0, 0, 0, 1, 0);
    chk("t4_frame_cnt", {16'd0, frame_cnt}, 3);
    for (int x = 0; x < 4; x++) step("t4_after", 1, 1, 1, 1, x, 0, 0, 0);
    step("t4_close", 1, 1, 0, 0, 0, 0, 0, 0);

    // Continuous pixels split by hsync edges.
    step("t6_vsync", 0, 1, 0, 0, 0, 0, 1, 0);
    chk("t6_frame_cnt", {16'd0, frame_cnt}, 4);
    step("t6_hs_closed", 1, 0, 0, 0, 0, 0, 0, 0);
    step("t6_idle", 1, 1, 0, 0, 0, 0, 0, 0);
    for (int x = 0; x < 4; x++) step("t6_l0", 1, 1, 1, 1, x, 0, 0, 0);
    step("t6_hs1", 1, 0, 1, 1, 0, 1, 0, 0);
    step("t6_l1", 1, 1, 1, 1, 1, 1, 0, 0);
    step("t6_hs2_short", 1, 0, 1, 1, 0, 2, 0, 1);
    step("t6_l2", 1, 1, 1, 1, 1, 2, 0, 0);
    step("t6_l2", 1, 1, 1, 1, 2, 2, 0, 0);
    step("t6_l2", 1, 1, 1, 1, 3, 2, 0, 0);
    step("t6_close", 1, 1, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a line.
    step("t5_vsync", 0, 1, 0, 0, 0, 0, 1, 0);
    step("t5_pix", 1, 1, 1, 1, 0, 0, 0, 0);
    step("t5_pix", 1, 1, 1, 1, 1, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk_zero("t5_async_reset");
    $display("[TB] t5 async reset applied mid-line");
    lx = 0; ly = 0;
    step("t5_in_reset", 1, 1, 1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("t5_idle_pix", 1, 1, 1, 0, 0, 0, 0, 0);
    step("t5_idle_close", 1, 1, 0, 0, 0, 0, 0, 0);
    step("t5_vsync2", 0, 1, 0, 0, 0, 0, 1, 0);
    chk("t5_frame_cnt", {16'd0, frame_cnt}, 1);
    step("t5_pix_after", 1, 1, 1, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
